// File: rtl/riscv_pkg.sv
// Shared opcode constants, the canonical NOP word and the fetch FSM state type.
package riscv_pkg;

  localparam logic [6:0]  OPC_HALT  = 7'b1111111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } fetch_state_e;

  function automatic logic is_halt(input logic [31:0] instr);
    return instr[6:0] == OPC_HALT;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory port between the fetch stage (master) and an async-read memory (slave).
interface if_stage_if #(
  parameter int unsigned PC_W = 9
);
  logic [PC_W-1:0] imem_addr_o;
  logic [31:0]     imem_rdata_i;

  modport master (output imem_addr_o, input imem_rdata_i);
  modport slave  (input imem_addr_o, output imem_rdata_i);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise holds.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int unsigned     PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            bubble,
  input  logic [PC_W-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     instr,
  output logic            valid
);

  logic [PC_W-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (bubble) begin
      // A bubble keeps the previous pc so downstream debug still sees a sensible value.
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load) begin
      pc_q    <= pc_in;
      instr_q <= instr_in;
      valid_q <= 1'b1;
    end
  end

  assign pc    = pc_q;
  assign instr = instr_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC register, RUN/DRAIN/HALTED control and the IF/ID register.
module if_stage
  import riscv_pkg::*;
#(
  parameter int unsigned     PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [PC_W-1:0]   branch_target_i,
  input  logic              halt_commit_i,
  if_stage_if.master        imem,
  output logic [PC_W-1:0]   ifid_pc_o,
  output logic [31:0]       ifid_instr_o,
  output logic              ifid_valid_o,
  output logic              halted_o
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            halted_q;
  logic            ifid_load, ifid_bubble;

  assign imem.imem_addr_o = pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    if (state_q == HALTED) begin
      ifid_bubble = 1'b1;
    end else if (flush_i) begin
      pc_d        = {branch_target_i[PC_W-1:2], 2'b00};
      ifid_bubble = 1'b1;
      state_d     = RUN;
    end else if (stall_i) begin
      // Hold everything, including a halt still parked in IF/ID.
    end else if (state_q == DRAIN) begin
      ifid_bubble = 1'b1;
      if (halt_commit_i) state_d = HALTED;
    end else begin
      ifid_load = 1'b1;
      if (is_halt(imem.imem_rdata_i)) state_d = DRAIN;
      else                            pc_d    = pc_q + PC_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= (state_d == HALTED);
    end
  end

  assign halted_o = halted_q;

  if_id_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .pc_in    (pc_q),
    .instr_in (imem.imem_rdata_i),
    .pc       (ifid_pc_o),
    .instr    (ifid_instr_o),
    .valid    (ifid_valid_o)
  );

endmodule
